// File: rtl/crack_sched.sv
`default_nettype none
// ============================================================================
// Module   : crack_sched
// Brief    : Copies a length-prefixed ciphertext into a multi-port buffer,
//            launches NENG crack engines and returns the first recovered key.
// Revision : 1.0
// ============================================================================
module crack_sched #(
    parameter int NENG = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                rdy,
    output logic [23:0]         key,
    output logic                key_valid,
    output logic [7:0]          ct_addr,
    input  logic [7:0]          ct_rddata,
    output logic [NENG-1:0]     eng_en,
    input  logic [NENG-1:0]     eng_rdy,
    input  logic [24*NENG-1:0]  eng_key,
    input  logic [NENG-1:0]     eng_key_valid,
    input  logic [8*NENG-1:0]   eng_ct_addr,
    output logic [8*NENG-1:0]   eng_ct_rddata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        LAUNCH = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        ct_addr_q, ct_addr_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [7:0]        len_q, len_d;
    logic              first_q, first_d;
    logic              skip_q, skip_d;
    logic [NENG-1:0]   done_q, done_d;
    logic [NENG-1:0]   eng_en_q, eng_en_d;
    logic [23:0]       key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic [8*NENG-1:0] eng_ct_rddata_q, eng_ct_rddata_d;

    logic              buf_we;
    logic [7:0]        buf_waddr;
    logic [7:0]        buf_wdata;
    logic [7:0]        len_eff;
    logic [NENG-1:0]   done_now;
    logic [NENG-1:0]   hit;
    logic [23:0]       key_sel;

    logic [7:0]        ct_buf [256];

    always_comb begin
        state_d     = state_q;
        ct_addr_d   = ct_addr_q;
        wr_addr_d   = wr_addr_q;
        len_d       = len_q;
        first_d     = first_q;
        skip_d      = skip_q;
        done_d      = done_q;
        eng_en_d    = '0;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        buf_we      = 1'b0;
        buf_waddr   = wr_addr_q;
        buf_wdata   = ct_rddata;
        // The length byte is usable in the very cycle it arrives.
        len_eff     = (wr_addr_q == 8'd0) ? ct_rddata : len_q;
        done_now    = done_q | (skip_q ? {NENG{1'b0}} : eng_rdy);
        hit         = done_now & eng_key_valid;
        key_sel     = '0;
        for (int i = NENG - 1; i >= 0; i--) begin
            if (hit[i]) key_sel = eng_key[24*i +: 24];
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = COPY;
                    ct_addr_d   = 8'd0;
                    wr_addr_d   = 8'd0;
                    len_d       = 8'd0;
                    first_d     = 1'b1;
                    key_d       = '0;
                    key_valid_d = 1'b0;
                end
            end
            COPY: begin
                if (first_q) begin
                    first_d   = 1'b0;
                    ct_addr_d = ct_addr_q + 8'd1;
                end else begin
                    buf_we = 1'b1;
                    if (wr_addr_q == 8'd0) len_d = ct_rddata;
                    if (wr_addr_q == len_eff) begin
                        state_d = LAUNCH;
                    end else begin
                        wr_addr_d = wr_addr_q + 8'd1;
                        if (ct_addr_q != len_eff) ct_addr_d = ct_addr_q + 8'd1;
                    end
                end
            end
            LAUNCH: begin
                // The pulse cycle itself is spent in LAUNCH; RUN begins after it.
                if (|eng_en_q) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                    done_d  = '0;
                end else if (&eng_rdy) begin
                    eng_en_d = '1;
                end
            end
            RUN: begin
                skip_d = 1'b0;
                done_d = done_now;
                if (|hit) begin
                    key_d       = key_sel;
                    key_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (&done_now) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        for (genvar g = 0; g < NENG; g++) begin : g_rd_port
            assign eng_ct_rddata_d[8*g +: 8] = ct_buf[eng_ct_addr[8*g +: 8]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (buf_we) ct_buf[buf_waddr] <= buf_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ct_addr_q       <= '0;
            wr_addr_q       <= '0;
            len_q           <= '0;
            first_q         <= 1'b0;
            skip_q          <= 1'b0;
            done_q          <= '0;
            eng_en_q        <= '0;
            key_q           <= '0;
            key_valid_q     <= 1'b0;
            eng_ct_rddata_q <= '0;
        end else begin
            state_q         <= state_d;
            ct_addr_q       <= ct_addr_d;
            wr_addr_q       <= wr_addr_d;
            len_q           <= len_d;
            first_q         <= first_d;
            skip_q          <= skip_d;
            done_q          <= done_d;
            eng_en_q        <= eng_en_d;
            key_q           <= key_d;
            key_valid_q     <= key_valid_d;
            eng_ct_rddata_q <= eng_ct_rddata_d;
        end
    end

    assign rdy           = (state_q == IDLE);
    assign key           = key_q;
    assign key_valid     = key_valid_q;
    assign ct_addr       = ct_addr_q;
    assign eng_en        = eng_en_q;
    assign eng_ct_rddata = eng_ct_rddata_q;

endmodule
`default_nettype wire

// File: tb/tb_crack_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_crack_sched
// Brief    : Randomized bench for crack_sched with external memory, engine
//            models and a job-level reference of copy, launch and key choice.
// Revision : 1.0
// ============================================================================
module tb_crack_sched;

    localparam int NENG = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                rdy;
    logic [23:0]         key;
    logic                key_valid;
    logic [7:0]          ct_addr;
    logic [7:0]          ct_rddata;
    logic [NENG-1:0]     eng_en;
    logic [NENG-1:0]     eng_rdy;
    logic [24*NENG-1:0]  eng_key;
    logic [NENG-1:0]     eng_key_valid;
    logic [8*NENG-1:0]   eng_ct_addr;
    logic [8*NENG-1:0]   eng_ct_rddata;

    crack_sched #(.NENG(NENG)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .rdy           (rdy),
        .key           (key),
        .key_valid     (key_valid),
        .ct_addr       (ct_addr),
        .ct_rddata     (ct_rddata),
        .eng_en        (eng_en),
        .eng_rdy       (eng_rdy),
        .eng_key       (eng_key),
        .eng_key_valid (eng_key_valid),
        .eng_ct_addr   (eng_ct_addr),
        .eng_ct_rddata (eng_ct_rddata)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          exp_pulse = -1;
    bit          keep_mem = 1'b0;

    logic [7:0]  ext_mem [256];
    logic [7:0]  prev_addr = '0;

    // engine models: busy window is [t_pulse+2, t_pulse+2+dur)
    int          t_pulse [NENG];
    int          dur     [NENG];
    logic [23:0] nkey [NENG], okey [NENG], cur_key [NENG];
    logic        nval [NENG], oval [NENG], cur_val [NENG];
    int          j_dur [NENG];
    logic [23:0] j_key [NENG];
    logic        j_val [NENG];

    logic [7:0]  ref_buf [256];
    int          buf_len = 0;
    bit          buf_ok  = 1'b0;
    bit          rd_pend = 1'b0;
    logic [7:0]  rd_addr [NENG];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        ct_rddata = ext_mem[prev_addr];
        prev_addr = ct_addr;
        if (rd_pend) begin
            for (int i = 0; i < NENG; i++)
                check_eq($sformatf("rd_port%0d", i), 32'(eng_ct_rddata[8*i +: 8]), 32'(ref_buf[rd_addr[i]]));
        end
        rd_pend = buf_ok;
        if (buf_ok) begin
            for (int i = 0; i < NENG; i++) begin
                rd_addr[i] = 8'($urandom_range(buf_len, 0));
                eng_ct_addr[8*i +: 8] = rd_addr[i];
            end
        end
        if (eng_en != '0) begin
            check_eq("eng_en_val", 32'(eng_en), 32'({NENG{1'b1}}));
            check_eq("pulse_cyc", cyc, exp_pulse);
            for (int i = 0; i < NENG; i++) begin
                okey[i] = cur_key[i];
                oval[i] = cur_val[i];
                t_pulse[i] = cyc;
                dur[i]  = j_dur[i];
                nkey[i] = j_key[i];
                nval[i] = j_val[i];
            end
        end
        for (int i = 0; i < NENG; i++) begin
            bit fin;
            fin = (t_pulse[i] >= 0) && (cyc >= t_pulse[i] + 2 + dur[i]);
            eng_rdy[i] = !((t_pulse[i] >= 0) && (cyc >= t_pulse[i] + 2) && !fin);
            cur_key[i] = fin ? nkey[i] : okey[i];
            cur_val[i] = fin ? nval[i] : oval[i];
            eng_key[24*i +: 24] = cur_key[i];
            eng_key_valid[i]    = cur_val[i];
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_rdy", 32'(rdy), 32'd1);
        check_eq("rst_key", 32'(key), 32'd0);
        check_eq("rst_key_valid", 32'(key_valid), 32'd0);
        check_eq("rst_eng_en", 32'(eng_en), 32'd0);
        check_eq("rst_ct_addr", 32'(ct_addr), 32'd0);
        check_eq("rst_rddata", 32'(eng_ct_rddata), 32'd0);
        buf_ok = 1'b0;
        rd_pend = 1'b0;
        exp_pulse = -1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_job(input int L, input int abort_copy, input int abort_run);
        int a, t, p, ep, best, d, n_hold;
        logic [23:0] ekey;
        logic ev;
        bit fin;
        step();
        en = 1'b0;
        check_eq("start_rdy", 32'(rdy), 32'd1);
        ext_mem[0] = 8'(L);
        if (!keep_mem) for (int j = 1; j < 256; j++) ext_mem[j] = 8'($urandom);
        en = 1'b1;
        buf_ok = 1'b0;
        a = cyc;
        for (int k = 0; k <= L + 1; k++) begin
            step();
            en = 1'($urandom);
            if (k == 0) begin
                check_eq("accept_key_clr", 32'(key), 32'd0);
                check_eq("accept_kv_clr", 32'(key_valid), 32'd0);
            end
            check_eq("copy_rdy", 32'(rdy), 32'd0);
            if (k <= L) check_eq("ct_addr", 32'(ct_addr), k);
            if (k == abort_copy) begin
                do_reset();
                return;
            end
        end
        for (int j = 0; j <= L; j++) ref_buf[j] = ext_mem[j];
        buf_len = L;
        buf_ok  = 1'b1;

        // launch happens once the copy is over and every engine is idle
        t = a + L + 3;
        for (int i = 0; i < NENG; i++)
            if (t_pulse[i] >= 0 && t_pulse[i] + 2 + dur[i] > t) t = t_pulse[i] + 2 + dur[i];
        ep = t + 1;
        exp_pulse = ep;
        p = -1;
        for (int n = 0; n < 400 && p < 0; n++) begin
            step();
            en = 1'($urandom);
            check_eq("launch_rdy", 32'(rdy), 32'd0);
            if (eng_en != '0) p = cyc;
        end
        exp_pulse = -1;
        if (p < 0) begin
            check_eq("launch_timeout", p, ep);
            return;
        end

        // earliest finishing engine with a key wins, lowest index on ties
        best = -1;
        for (int i = 0; i < NENG; i++)
            if (j_val[i] && (best < 0 || j_dur[i] < j_dur[best])) best = i;
        if (best >= 0) begin
            d = j_dur[best]; ekey = j_key[best]; ev = 1'b1;
        end else begin
            d = 0;
            for (int i = 0; i < NENG; i++) if (j_dur[i] > d) d = j_dur[i];
            ekey = '0; ev = 1'b0;
        end

        fin = 1'b0;
        for (int n = 0; n < 400 && !fin; n++) begin
            step();
            if (eng_en != '0) check_eq("run_eng_en", 32'(eng_en), 32'd0);
            if (rdy) begin
                en = 1'b0;
                fin = 1'b1;
            end else begin
                en = 1'($urandom);
                if (n == abort_run) begin
                    do_reset();
                    return;
                end
            end
        end
        check_eq("done_cyc", fin ? cyc : -1, p + 3 + d);
        check_eq("key", 32'(key), 32'(ekey));
        check_eq("key_valid", 32'(key_valid), 32'(ev));
        n_hold = $urandom_range(3, 1);
        for (int h = 0; h < n_hold; h++) begin
            step();
            en = 1'b0;
            check_eq("hold_rdy", 32'(rdy), 32'd1);
            check_eq("hold_key", 32'(key), 32'(ekey));
            check_eq("hold_kv", 32'(key_valid), 32'(ev));
        end
    endtask

    task automatic set_job(input int d0, input int d1, input logic v0, input logic v1,
                           input logic [23:0] k0, input logic [23:0] k1);
        j_dur[0] = d0; j_dur[1] = d1;
        j_val[0] = v0; j_val[1] = v1;
        j_key[0] = k0; j_key[1] = k1;
    endtask

    task automatic rand_job();
        for (int i = 0; i < NENG; i++) begin
            j_dur[i] = $urandom_range(30, 1);
            j_val[i] = 1'($urandom_range(1, 0));
            j_key[i] = 24'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        ct_rddata = '0;
        eng_ct_addr = '0;
        for (int i = 0; i < NENG; i++) begin
            t_pulse[i] = -1; dur[i] = 0;
            okey[i] = '0; oval[i] = 1'b0; nkey[i] = '0; nval[i] = 1'b0;
            cur_key[i] = '0; cur_val[i] = 1'b0; rd_addr[i] = '0;
        end
        eng_rdy = '1;
        eng_key = '0;
        eng_key_valid = '0;
        for (int j = 0; j < 256; j++) begin
            ext_mem[j] = '0;
            ref_buf[j] = '0;
        end
        #1;
        check_eq("init_rdy", 32'(rdy), 32'd1);
        check_eq("init_key_valid", 32'(key_valid), 32'd0);
        check_eq("init_eng_en", 32'(eng_en), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // copy of a fixed 3-byte message, then a direct buffer read
        keep_mem = 1'b1;
        ext_mem[1] = 8'h12; ext_mem[2] = 8'h0E; ext_mem[3] = 8'h37;
        set_job(4, 6, 1'b1, 1'b1, 24'h00ABCD, 24'h001234);
        run_job(3, -1, -1);
        keep_mem = 1'b0;
        buf_ok = 1'b0;
        step();
        eng_ct_addr[7:0] = 8'd2;
        step();
        check_eq("rd_addr2", 32'(eng_ct_rddata[7:0]), 32'h0E);

        // engine 1 finds while engine 0 keeps running; next launch must wait
        set_job(40, 5, 1'b0, 1'b1, 24'h0, 24'h000003);
        run_job(2, -1, -1);
        set_job(3, 3, 1'b1, 1'b0, 24'h5A5A5A, 24'h111111);
        run_job(0, -1, -1);

        // simultaneous valid keys, then no key at all
        set_job(7, 7, 1'b1, 1'b1, 24'h00000A, 24'h00000B);
        run_job(2, -1, -1);
        set_job(4, 9, 1'b0, 1'b0, 24'h777777, 24'h888888);
        run_job(1, -1, -1);

        // reset while a found key is held
        set_job(2, 6, 1'b1, 1'b0, 24'hC0FFEE, 24'h0);
        run_job(4, -1, -1);
        do_reset();

        // reset mid-run and mid-copy, each followed by a clean job
        set_job(20, 25, 1'b1, 1'b1, 24'h123456, 24'h654321);
        run_job(5, -1, 3);
        set_job(3, 2, 1'b0, 1'b1, 24'h0, 24'hFEDCBA);
        run_job(6, -1, -1);
        rand_job();
        run_job(10, 4, -1);
        rand_job();
        run_job(8, -1, -1);

        for (int r = 0; r < 25; r++) begin
            rand_job();
            run_job(($urandom_range(9, 0) == 0) ? 255 : int'($urandom_range(40, 0)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crack_sched.md
CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 Parameter NENG, default 2: number of attached crack engines, 2..4; packed bus widths scale with NENG.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  start request, sampled only while rdy=1.
REQ-005 rdy  output  1  scheduler idle, ready for en.
REQ-006 key  output  24  recovered key, meaningful when rdy=1.
REQ-007 key_valid  output  1  key holds a found key, meaningful when rdy=1.
REQ-008 ct_addr  output  8  read address to shared ciphertext memory.
REQ-009 ct_rddata  input  8  memory data, valid one cycle after ct_addr.
REQ-010 eng_en  output  NENG  per-engine start pulse.
REQ-011 eng_rdy  input  NENG  per-engine ready.
REQ-012 eng_key  input  24*NENG  per-engine key, engine i at bits [24i+23:24i].
REQ-013 eng_key_valid  input  NENG  per-engine key found.
REQ-014 eng_ct_addr  input  8*NENG  per-engine buffer read address.
REQ-015 eng_ct_rddata  output  8*NENG  per-engine buffer data, one-cycle latency.

Function
REQ-016 The block SHALL hold a 256x8 internal ciphertext buffer with NENG independent read ports and one write port.
REQ-017 States SHALL be IDLE, COPY, LAUNCH, RUN; rdy SHALL be 1 only in IDLE.
REQ-018 IDLE->COPY SHALL occur on a clock edge with en=1; en in any other state SHALL be ignored.
REQ-019 COPY SHALL drive ct_addr = 0,1,2,... on consecutive cycles from the first COPY cycle, and write the ct_rddata returned for address i into buffer[i] one cycle later.
REQ-020 The byte read from address 0 SHALL be latched as length L; COPY SHALL stop after address L is issued and its data written, taking L+2 cycles in total.
REQ-021 L=0 SHALL copy only address 0 and proceed to LAUNCH.
REQ-022 LAUNCH SHALL wait until every eng_rdy bit is 1, then pulse eng_en all-ones for exactly one cycle and enter RUN.
REQ-023 RUN SHALL ignore eng_rdy for the first cycle after the pulse. An engine is done when eng_rdy[i]=1 thereafter.
REQ-024 RUN SHALL complete on the first cycle in which any done engine has eng_key_valid=1; key SHALL take that engine's eng_key and key_valid SHALL be 1.
REQ-025 If several done engines report valid in the same cycle, the lowest index SHALL win.
REQ-026 If all engines are done and none reports valid, RUN SHALL complete with key=0 and key_valid=0.
REQ-027 On completion the block SHALL return to IDLE on the next edge. key/key_valid SHALL hold until the next en is accepted, then clear to 0.
REQ-028 Engines still running at completion SHALL NOT be aborted; a following LAUNCH SHALL wait for them per REQ-022.
REQ-029 eng_ct_rddata[i] SHALL equal buffer[eng_ct_addr[i]] registered one cycle after the address, in every state.
REQ-030 eng_en SHALL be 0 outside the single LAUNCH pulse cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, rdy=1, key=0, key_valid=0, eng_en=0, ct_addr=0, eng_ct_rddata=0, L=0.
REQ-032 Reset in any state, including mid-COPY or mid-RUN, SHALL abandon the operation; buffer contents are undefined afterwards.

Verification
REQ-033 Reset: assert rst_n=0 mid-cycle -> rdy=1, key_valid=0, key=0, eng_en=0 without waiting for a clock edge.
REQ-034 Copy: memory {3,0x12,0x0E,0x37}, en pulse -> ct_addr 0,1,2,3, rdy=0 for the copy. Afterwards eng_ct_addr[0]=2 returns 0x0E one cycle later.
REQ-035 Single find: engine 1 rdy with key 0x000003 valid while engine 0 busy -> key=0x000003, key_valid=1, rdy=1. The next LAUNCH waits for engine 0's rdy.
REQ-036 Tie: both engines done with valid keys 0x00000A and 0x00000B in the same cycle -> key=0x00000A.
REQ-037 No key: all engines done with eng_key_valid=0 -> key_valid=0, key=0, rdy=1.
REQ-038 Robustness: en=1 during RUN -> ignored. rst_n pulse during RUN -> IDLE, then a new en performs a full COPY from address 0.
